// File: rtl/crc16_frame_ctrl.sv
// rtl/crc16_frame_ctrl.sv - byte-to-bit sequencer driving one bit-serial crc16 engine
// Clears the engine per frame, shifts each accepted byte in over 8 cycles, captures the result.
module crc16_frame_ctrl #(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic        crc_rst,
  output logic        crc_en,
  output logic        crc_data,
  input  logic [15:0] crc_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] crc_out,
  output logic [15:0] frame_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_SHIFT,
    S_FINISH,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        last_q, last_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic [15:0] crc_out_q, crc_out_d;
  logic        data_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      last_q      <= 1'b0;
      frame_len_q <= 16'h0000;
      crc_out_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      last_q      <= last_d;
      frame_len_q <= frame_len_d;
      crc_out_q   <= crc_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    last_d      = last_q;
    frame_len_d = frame_len_q;
    crc_out_d   = crc_out_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CLEAR;
          frame_len_d = 16'h0000;
        end
      end
      S_CLEAR: state_d = S_WAIT;
      S_WAIT: begin
        if (byte_valid) begin
          shreg_d     = byte_data;
          last_d      = byte_last;
          bit_cnt_d   = 3'd0;
          frame_len_d = (frame_len_q == 16'hFFFF) ? frame_len_q : frame_len_q + 16'd1;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d   = LSB_FIRST ? {1'b0, shreg_q[7:1]} : {shreg_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = last_q ? S_FINISH : S_WAIT;
      end
      S_FINISH: begin
        crc_out_d = crc_in;
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort drops everything in flight; the partial length and old result stay visible.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      last_d      = last_q;
      frame_len_d = frame_len_q;
      crc_out_d   = crc_out_q;
    end
  end

  assign data_bit   = LSB_FIRST ? shreg_q[0] : shreg_q[7];
  assign byte_ready = (state_q == S_WAIT);
  assign crc_rst    = (state_q == S_CLEAR);
  assign crc_en     = (state_q == S_SHIFT);
  assign crc_data   = (state_q == S_SHIFT) & data_bit;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign crc_out    = crc_out_q;
  assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// tb/tb_crc16_frame_ctrl.sv - scoreboard bench for crc16_frame_ctrl (both bit orders)
module tb_crc16_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_last = 1'b0;

  logic        byte_ready0, crc_rst0, crc_en0, crc_data0, busy0, done0;
  logic [15:0] crc_out0, frame_len0, eng0_q;
  logic        byte_ready1, crc_rst1, crc_en1, crc_data1, busy1, done1;
  logic [15:0] crc_out1, frame_len1, eng1_q;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_clears = 0;
  int exp_clears = 0;

  logic [7:0]  fb [4];
  logic [7:0]  bitq0 [$];
  logic [7:0]  bitq1 [$];
  logic [31:0] fq0 [$];
  logic [31:0] fq1 [$];
  logic [15:0] last_exp0 = 16'h0000;
  logic [15:0] last_exp1 = 16'h0000;
  int          done_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc16_frame_ctrl #(.LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready0), .crc_rst(crc_rst0), .crc_en(crc_en0), .crc_data(crc_data0),
    .crc_in(eng0_q), .busy(busy0), .done(done0), .crc_out(crc_out0), .frame_len(frame_len0)
  );

  crc16_frame_ctrl #(.LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready1), .crc_rst(crc_rst1), .crc_en(crc_en1), .crc_data(crc_data1),
    .crc_in(eng1_q), .busy(busy1), .done(done1), .crc_out(crc_out1), .frame_len(frame_len1)
  );

  // CRC-16/CCITT bit-serial engine stand-in, cleared to 0xFFFF
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || crc_rst0) eng0_q <= 16'hFFFF;
    else if (crc_en0)    eng0_q <= crc_step(eng0_q, crc_data0);
  end

  always_ff @(posedge clk) begin
    if (rst || crc_rst1) eng1_q <= 16'hFFFF;
    else if (crc_en1)    eng1_q <= crc_step(eng1_q, crc_data1);
  end

  function automatic logic [15:0] model_crc(input int n, input bit lsb);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++)
        c = crc_step(c, lsb ? fb[i][j] : fb[i][7-j]);
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor: rebuilds shifted bytes, checks captured results against the scoreboard.
  initial begin
    int bc0, bc1;
    logic [7:0] acc0, acc1;
    logic [31:0] e;
    bc0 = 0; bc1 = 0; acc0 = 8'h00; acc1 = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        bc0 = 0; bc1 = 0;
      end else begin
        if (crc_en0) begin
          acc0 = {acc0[6:0], crc_data0};
          bc0++;
          if (bc0 == 8) begin
            bc0 = 0;
            if (bitq0.size() == 0) fail("bits_msb_unexpected");
            else chk("bits_msb_first", acc0, bitq0.pop_front());
          end
        end
        if (crc_en1) begin
          acc1 = {crc_data1, acc1[7:1]};
          bc1++;
          if (bc1 == 8) begin
            bc1 = 0;
            if (bitq1.size() == 0) fail("bits_lsb_unexpected");
            else chk("bits_lsb_first", acc1, bitq1.pop_front());
          end
        end
        if (done0) begin
          if (fq0.size() == 0) fail("done0_unexpected");
          else begin
            e = fq0.pop_front();
            chk("crc_out_msb", crc_out0, e[31:16]);
            chk("frame_len_msb", frame_len0, e[15:0]);
          end
        end
        if (done1) begin
          if (fq1.size() == 0) fail("done1_unexpected");
          else begin
            e = fq1.pop_front();
            chk("crc_out_lsb", crc_out1, e[31:16]);
            chk("frame_len_lsb", frame_len1, e[15:0]);
          end
        end
        if (byte_ready0) chk("no_en_in_wait", crc_en0, 0);
        if (crc_rst0) n_clears++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (byte_ready0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_frame(input int n, input int gap, input bit hold_start, input bit abort_at_start);
    int c0, k;
    bit ok;
    fq0.push_back({model_crc(n, 1'b0), 16'(n)});
    fq1.push_back({model_crc(n, 1'b1), 16'(n)});
    last_exp0 = model_crc(n, 1'b0);
    last_exp1 = model_crc(n, 1'b1);
    exp_clears++;
    k = 0;
    @(posedge clk); #1;
    start = 1'b1; abort = abort_at_start;
    byte_valid = 1'b1; byte_data = fb[0]; byte_last = (n == 1);
    @(posedge clk); #1;
    c0 = cyc;
    abort = 1'b0;
    if (!hold_start) start = 1'b0;
    for (int i = 0; i < n; i++) begin
      wait_ready(ok);
      if (!ok) begin
        chk("handshake_seen", 0, 1);
        byte_valid = 1'b0; start = 1'b0;
        return;
      end
      k = cyc - c0 + 1;
      bitq0.push_back(fb[i]);
      bitq1.push_back(fb[i]);
      @(posedge clk); #1;
      if (i == n - 1) begin
        byte_valid = 1'b0; start = 1'b0;
      end else begin
        if (gap > 0) begin
          byte_valid = 1'b0;
          repeat (gap) @(posedge clk);
          #1;
        end
        byte_valid = 1'b1; byte_data = fb[i+1]; byte_last = (i + 1 == n - 1);
      end
    end
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done0) begin ok = 1'b1; break; end
    end
    chk("done_seen", ok, 1);
    done_cyc = cyc - c0 + 1;
    chk("done_cycle", done_cyc, k + 10);
    @(negedge clk);
    chk("idle_after_done", busy0, 0);
  endtask

  initial begin
    bit ok;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_ready", byte_ready0, 0);
    chk("rst_crc_rst", crc_rst0, 0);
    chk("rst_crc_en", crc_en0, 0);
    chk("rst_done", done0, 0);
    chk("rst_crc_out", crc_out0, 16'h0000);
    chk("rst_frame_len", frame_len0, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    fb[0] = 8'hA5;
    run_frame(1, 0, 1'b0, 1'b0);
    chk("single_byte_done_cycle", done_cyc, 12);

    fb[0] = 8'h01;
    run_frame(1, 0, 1'b0, 1'b0);

    fb[0] = 8'h12; fb[1] = 8'h34; fb[2] = 8'h56;
    run_frame(3, 2, 1'b0, 1'b0);

    // Abort in WAIT after one non-last byte.
    exp_clears++;
    @(posedge clk); #1;
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'h3C; byte_last = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    wait_ready(ok);
    chk("abort_first_ready", ok, 1);
    bitq0.push_back(8'h3C);
    bitq1.push_back(8'h3C);
    @(posedge clk); #1 byte_valid = 1'b0;
    wait_ready(ok);
    chk("abort_second_ready", ok, 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_frame_len", frame_len0, 16'd1);
    chk("abort_crc_out_msb", crc_out0, last_exp0);
    chk("abort_crc_out_lsb", crc_out1, last_exp1);
    repeat (12) @(posedge clk);

    fb[0] = 8'hA5;
    run_frame(1, 0, 1'b0, 1'b1);

    fb[0] = 8'hDE; fb[1] = 8'hAD;
    run_frame(2, 1, 1'b1, 1'b0);

    // Reset during the 3rd SHIFT cycle of a 0xFF byte.
    exp_clears++;
    @(posedge clk); #1;
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'hFF; byte_last = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (crc_en0) n++;
      if (n == 3) break;
    end
    chk("reached_third_shift", n, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_crc_en", crc_en0, 0);
    chk("arst_crc_data_msb", crc_data0, 0);
    chk("arst_crc_data_lsb", crc_data1, 0);
    chk("arst_crc_out", crc_out0, 16'h0000);
    chk("arst_frame_len", frame_len0, 16'h0000);
    byte_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    fb[0] = 8'h5A;
    run_frame(1, 0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("frames_pending_msb", fq0.size(), 0);
    chk("frames_pending_lsb", fq1.size(), 0);
    chk("bytes_pending_msb", bitq0.size(), 0);
    chk("bytes_pending_lsb", bitq1.size(), 0);
    chk("clear_cycles", n_clears, exp_clears);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc16_frame_ctrl.md
# crc16_frame_ctrl

Byte-level sequencer for the bit-serial `crc16` engine. It accepts a frame of bytes over a valid/ready handshake, clears the engine at frame start, and shifts each byte into the engine one bit per clock. At end of frame it captures the 16-bit result and reports it with a one-cycle `done` pulse. It sits between a byte-stream source (UART/packet logic) and one `crc16` instance, and owns that instance's `rst`, `en` and `data` inputs exclusively.

## Interface

Parameters:
- `LSB_FIRST`, default 0: bit order fed to the engine. 0 feeds bit 7 first; 1 feeds bit 0 first.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  begin a new frame; sampled only in IDLE.
- `abort`  in  1  abandon the current frame; highest priority after `rst`.
- `byte_valid`  in  1  source has a byte.
- `byte_data`  in  8  byte value.
- `byte_last`  in  1  this byte ends the frame; qualified by handshake.
- `byte_ready`  out  1  controller accepts a byte this cycle.
- `crc_rst`  out  1  drives engine `rst`.
- `crc_en`  out  1  drives engine `en`.
- `crc_data`  out  1  drives engine `data`.
- `crc_in`  in  16  engine `crc` output.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `crc_out` is valid.
- `crc_out`  out  16  captured CRC; held until the next capture or reset.
- `frame_len`  out  16  bytes accepted in the current or last frame; saturates at 0xFFFF.

## Operation

- States: IDLE, CLEAR, WAIT, SHIFT, FINISH, DONE.
- IDLE: `start` moves to CLEAR and zeroes `frame_len`. `byte_ready` is 0. Bytes presented in IDLE are not consumed.
- CLEAR: lasts one cycle. `crc_rst`=1 and `crc_en`=0. Next state is WAIT.
- WAIT: `byte_ready`=1. On `byte_valid`&`byte_ready`:
  - latch `byte_data` into the shift register and `byte_last` into a flag;
  - increment `frame_len`, saturating;
  - clear the 3-bit bit counter and go to SHIFT.
- SHIFT: lasts exactly 8 cycles. `crc_en`=1.
  - `crc_data` = shift-register bit 7 (`LSB_FIRST`=0) or bit 0 (`LSB_FIRST`=1).
  - The register shifts each cycle and the bit counter increments each cycle.
  - After the 8th cycle the next state is FINISH if the last flag is set, otherwise WAIT.
- FINISH: lasts one cycle. `crc_en`=0, so the engine has absorbed the final bit. `crc_out` <= `crc_in`. Next state is DONE.
- DONE: lasts one cycle. `done`=1. Next state is IDLE.
- `crc_en` is 1 only in SHIFT. `crc_rst` is 1 only in CLEAR. `crc_data` is 0 outside SHIFT.
- `abort` in any non-IDLE state goes to IDLE at the next edge:
  - no `done` pulse;
  - `crc_out` is unchanged;
  - `frame_len` keeps its partial count.
- `start` while `busy` is ignored.
- Simultaneous `abort` and `start` in IDLE: `start` wins, because `abort` has no effect in IDLE.
- `rst` asserted forces:
  - state to IDLE;
  - `crc_out`, `frame_len` and the shift register to 0;
  - every output to 0, including `crc_rst`.
- The engine is re-cleared by CLEAR at the next frame start.
- Zero-length frames are not supported. A frame always contains at least one byte with `byte_last`=1.

## Timing

- Edge 0 samples `start`. Cycle 1 is CLEAR. Cycle 2 is WAIT.
- A byte handshaken in cycle k produces SHIFT in cycles k+1..k+8.
  - The next WAIT is cycle k+9.
  - Minimum throughput is 9 cycles per byte.
- For the last byte handshaken in cycle k:
  - FINISH is cycle k+9;
  - `done`=1 in cycle k+10, with `crc_out` already valid in that cycle;
  - IDLE from cycle k+11.
- A 1-byte frame with `byte_valid` held high: `start` at edge 0 gives `done` in cycle 12.
- `byte_ready` is combinational from state only and has no dependence on `byte_valid`.
- Outputs are registered or decoded from state. There is no combinational path from any input to any output.

## Test plan

- Reset mid-SHIFT:
  - stimulus: assert `rst` during the 3rd SHIFT cycle;
  - response: `busy`, `crc_en`, `crc_data`, `crc_out` and `frame_len` all read 0 immediately, asynchronously, without waiting for a clock edge.
- Single byte 0xA5, `LSB_FIRST`=0:
  - response: `crc_data` = 1,0,1,0,0,1,0,1 over 8 consecutive `crc_en` cycles;
  - `done` in cycle 12 after `start`;
  - `crc_out` equals the reference `crc16` model for 0xA5; `frame_len`=1.
- Single byte 0xA5, `LSB_FIRST`=1: `crc_data` = 1,0,1,0,0,1,0,1 (bit 0 first; the pattern is palindromic). Repeat with 0x01 and check 1,0,0,0,0,0,0,0.
- Three bytes 0x12,0x34,0x56, with `byte_valid` toggling and 2 idle cycles between bytes:
  - no `crc_en` while in WAIT;
  - `frame_len`=3;
  - `crc_out` matches the model over 24 bits;
  - exactly one `done` pulse.
- `abort` in WAIT after 1 byte: returns to IDLE, no `done`, `crc_out` keeps its previous value. A following frame of 0xA5 yields the same `crc_out` as the single-byte test, proving CLEAR re-initialises the engine.
- `start` asserted repeatedly while `busy`: no restart, no extra CLEAR cycle; the in-flight CRC result is unaffected.
